cc_level_controller: RTL

- Game-progress sequencer for the Road Fighter datapath.
- Counts distance ticks and derives the current level from distance, using the same thresholds as the level comparator: >30 gives level 3, >10 gives level 2, else level 1.
- On each level increase, freezes play for a level-up announcement window. Also handles crash penalty pauses and end-of-track.
- Drives the scroll-speed period consumed by the road/obstacle generators.

---
 rtl/cc_level_controller_if.sv | 45 ++++
 rtl/cc_level_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cc_level_controller_if.sv
// Game-progress bus for cc_level_controller: control pulses into the
// sequencer and its registered distance/level/speed/status outputs.
// master = game logic driving pulses, slave = the sequencer itself.
interface cc_level_controller_if #(
  parameter int DIST_WIDTH = 8
);
  // Pulses into the sequencer, one cycle each
  logic                  CC_LEVEL_CONTROLLER_Start_InHigh;
  logic                  CC_LEVEL_CONTROLLER_Tick_InHigh;
  logic                  CC_LEVEL_CONTROLLER_Crash_InHigh;
  // Registered progress and status
  logic [DIST_WIDTH-1:0] CC_LEVEL_CONTROLLER_Distance_OutBus;
  logic [1:0]            CC_LEVEL_CONTROLLER_Level_OutBus;
  logic [3:0]            CC_LEVEL_CONTROLLER_Speed_OutBus;
  logic                  CC_LEVEL_CONTROLLER_Running_OutHigh;
  logic                  CC_LEVEL_CONTROLLER_Announce_OutHigh;
  logic                  CC_LEVEL_CONTROLLER_Crashed_OutHigh;
  logic                  CC_LEVEL_CONTROLLER_Finish_OutHigh;

  modport master (
    output CC_LEVEL_CONTROLLER_Start_InHigh,
    output CC_LEVEL_CONTROLLER_Tick_InHigh,
    output CC_LEVEL_CONTROLLER_Crash_InHigh,
    input  CC_LEVEL_CONTROLLER_Distance_OutBus,
    input  CC_LEVEL_CONTROLLER_Level_OutBus,
    input  CC_LEVEL_CONTROLLER_Speed_OutBus,
    input  CC_LEVEL_CONTROLLER_Running_OutHigh,
    input  CC_LEVEL_CONTROLLER_Announce_OutHigh,
    input  CC_LEVEL_CONTROLLER_Crashed_OutHigh,
    input  CC_LEVEL_CONTROLLER_Finish_OutHigh
  );

  modport slave (
    input  CC_LEVEL_CONTROLLER_Start_InHigh,
    input  CC_LEVEL_CONTROLLER_Tick_InHigh,
    input  CC_LEVEL_CONTROLLER_Crash_InHigh,
    output CC_LEVEL_CONTROLLER_Distance_OutBus,
    output CC_LEVEL_CONTROLLER_Level_OutBus,
    output CC_LEVEL_CONTROLLER_Speed_OutBus,
    output CC_LEVEL_CONTROLLER_Running_OutHigh,
    output CC_LEVEL_CONTROLLER_Announce_OutHigh,
    output CC_LEVEL_CONTROLLER_Crashed_OutHigh,
    output CC_LEVEL_CONTROLLER_Finish_OutHigh
  );
endinterface

// File: rtl/cc_level_controller.sv
// Road Fighter progress sequencer: counts distance ticks, derives level,
// runs level-up announce and crash-penalty freezes, and ends the race.
// Ports: CLOCK_50, synchronous active-high RESET, bus_if (slave) carrying
// Start/Tick/Crash pulses in and Distance/Level/Speed/status flags out.
// Latency: every output is registered, updating one cycle after its cause.
// Backpressure: none; pulses arriving in a state that ignores them are lost.
module cc_level_controller #(
  parameter int         DIST_WIDTH      = 8,
  parameter int         L2_THRESHOLD    = 10,
  parameter int         L3_THRESHOLD    = 30,
  parameter int         FINISH_DISTANCE = 60,
  parameter int         ANNOUNCE_TICKS  = 4,
  parameter int         CRASH_TICKS     = 6,
  parameter logic [3:0] SPEED_L1        = 4'd8,
  parameter logic [3:0] SPEED_L2        = 4'd5,
  parameter logic [3:0] SPEED_L3        = 4'd3
) (
  input  logic                    CC_LEVEL_CONTROLLER_CLOCK_50,
  input  logic                    CC_LEVEL_CONTROLLER_RESET_InHigh,
  cc_level_controller_if.slave    bus_if
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_ANNOUNCE,
    ST_CRASH,
    ST_FINISH
  } state_e;

  // Phase counter covers the longer of the two freeze windows
  localparam int PH_MAX = (ANNOUNCE_TICKS > CRASH_TICKS) ? ANNOUNCE_TICKS : CRASH_TICKS;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

  localparam logic [DIST_WIDTH-1:0] L2_D     = DIST_WIDTH'(L2_THRESHOLD);
  localparam logic [DIST_WIDTH-1:0] L3_D     = DIST_WIDTH'(L3_THRESHOLD);
  localparam logic [DIST_WIDTH-1:0] FINISH_D = DIST_WIDTH'(FINISH_DISTANCE);
  localparam logic [PH_W-1:0]       ANN_LAST = PH_W'(ANNOUNCE_TICKS - 1);
  localparam logic [PH_W-1:0]       CR_LAST  = PH_W'(CRASH_TICKS - 1);

  state_e                 state_q, state_d;
  logic [DIST_WIDTH-1:0]  dist_q, dist_d;
  logic [1:0]             level_q, level_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [3:0]             speed_q, speed_d;
  logic                   running_q, announce_q, crashed_q, finish_q;

  logic [DIST_WIDTH-1:0]  dist_inc;
  logic [1:0]             level_inc;

  function automatic logic [1:0] level_of(input logic [DIST_WIDTH-1:0] d);
    if (d > L3_D)      return 2'b11;
    else if (d > L2_D) return 2'b10;
    else               return 2'b01;
  endfunction

  // FINISH stops counting before the counter could ever wrap
  assign dist_inc  = dist_q + DIST_WIDTH'(1);
  assign level_inc = level_of(dist_inc);

  always_comb begin
    state_d = state_q;
    dist_d  = dist_q;
    level_d = level_q;
    phase_d = phase_q;

    unique case (state_q)
      ST_IDLE: begin
        dist_d  = '0;
        level_d = 2'b01;
        if (bus_if.CC_LEVEL_CONTROLLER_Start_InHigh) state_d = ST_RUN;
      end

      ST_RUN: begin
        // Crash outranks a coincident tick; that tick's distance is lost
        if (bus_if.CC_LEVEL_CONTROLLER_Crash_InHigh) begin
          state_d = ST_CRASH;
          phase_d = '0;
        end else if (bus_if.CC_LEVEL_CONTROLLER_Tick_InHigh) begin
          dist_d = dist_inc;
          // Level is monotonic; the max guards against lower thresholds
          if (level_inc > level_q) level_d = level_inc;
          if (dist_inc == FINISH_D) begin
            state_d = ST_FINISH;
          end else if (level_inc > level_q) begin
            state_d = ST_ANNOUNCE;
            phase_d = '0;
          end
        end
      end

      ST_ANNOUNCE: begin
        if (bus_if.CC_LEVEL_CONTROLLER_Tick_InHigh) begin
          if (phase_q == ANN_LAST) begin
            state_d = ST_RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end

      ST_CRASH: begin
        // Extra crash pulses deliberately do not restart the penalty
        if (bus_if.CC_LEVEL_CONTROLLER_Tick_InHigh) begin
          if (phase_q == CR_LAST) begin
            state_d = ST_RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end

      ST_FINISH: begin
        if (bus_if.CC_LEVEL_CONTROLLER_Start_InHigh) begin
          dist_d  = '0;
          level_d = 2'b01;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Speed looks ahead at the next state/level so it lines up with the flags
  always_comb begin
    speed_d = 4'd0;
    if (state_d == ST_RUN) begin
      unique case (level_d)
        2'b11:   speed_d = SPEED_L3;
        2'b10:   speed_d = SPEED_L2;
        default: speed_d = SPEED_L1;
      endcase
    end
  end

  always_ff @(posedge CC_LEVEL_CONTROLLER_CLOCK_50) begin
    if (CC_LEVEL_CONTROLLER_RESET_InHigh) begin
      state_q    <= ST_IDLE;
      dist_q     <= '0;
      level_q    <= 2'b01;
      phase_q    <= '0;
      speed_q    <= 4'd0;
      running_q  <= 1'b0;
      announce_q <= 1'b0;
      crashed_q  <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dist_q     <= dist_d;
      level_q    <= level_d;
      phase_q    <= phase_d;
      speed_q    <= speed_d;
      running_q  <= (state_d == ST_RUN);
      announce_q <= (state_d == ST_ANNOUNCE);
      crashed_q  <= (state_d == ST_CRASH);
      finish_q   <= (state_d == ST_FINISH);
    end
  end

  assign bus_if.CC_LEVEL_CONTROLLER_Distance_OutBus  = dist_q;
  assign bus_if.CC_LEVEL_CONTROLLER_Level_OutBus     = level_q;
  assign bus_if.CC_LEVEL_CONTROLLER_Speed_OutBus     = speed_q;
  assign bus_if.CC_LEVEL_CONTROLLER_Running_OutHigh  = running_q;
  assign bus_if.CC_LEVEL_CONTROLLER_Announce_OutHigh = announce_q;
  assign bus_if.CC_LEVEL_CONTROLLER_Crashed_OutHigh  = crashed_q;
  assign bus_if.CC_LEVEL_CONTROLLER_Finish_OutHigh   = finish_q;

endmodule
